// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multi-cycle MIPS32 integer core. An FSM sequences a shared datapath
//   (register file, ALU, IR/A/B/ALUOut/MDR latches). Instruction fetches and
//   lw/sw accesses share one memory port with a req/ready handshake, so
//   memory of any latency can be attached.
//
//   Supported: add sub and or slt sll srl (R-type), addi, lw, sw, beq, j,
//   plus a halt opcode (HALT_OP). Any other opcode/funct retires as a NOP
//   and pulses illegal_op.
//
// Ports
//   clk, reset   rising-edge clock, synchronous active-high reset
//   mem_req      memory request valid
//   mem_we       1 = write (sw), 0 = read (fetch, lw)
//   mem_addr     word-aligned byte address
//   mem_wdata    store data
//   mem_rdata    read data, valid while mem_ready = 1
//   mem_ready    completes a request when high together with mem_req
//   halted       core sits in HALT
//   illegal_op   1-cycle pulse for an unsupported instruction
//   retire       1-cycle pulse per completed instruction
//   retire_pc    address of the retiring instruction
//   wb_en        register write this cycle (never for $0)
//   wb_reg       destination register
//   wb_data      value written
module mips_multicycle_core #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [5:0]  HALT_OP  = 6'h3F
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              illegal_op,
  output logic              retire,
  output logic [ADDR_W-1:0] retire_pc,
  output logic              wb_en,
  output logic [4:0]        wb_reg,
  output logic [31:0]       wb_data
);

  localparam logic [2:0] S_FETCH_WAIT0 = 3'd0;
  localparam logic [2:0] S_FETCH       = 3'd1;
  localparam logic [2:0] S_DECODE      = 3'd2;
  localparam logic [2:0] S_EXEC        = 3'd3;
  localparam logic [2:0] S_MEM         = 3'd4;
  localparam logic [2:0] S_WB          = 3'd5;
  localparam logic [2:0] S_HALT        = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] cur_pc;
  logic [31:0]       ir;
  logic [31:0]       a_reg;
  logic [31:0]       b_reg;
  logic [31:0]       alu_out;
  logic [31:0]       mdr;
  logic [31:0]       regs [32];

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] sext_imm;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign shamt    = ir[10:6];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign sext_imm = {{16{imm[15]}}, imm};

  logic [31:0] pc32;
  logic [31:0] jump32;
  logic [31:0] branch32;

  assign pc32     = 32'(pc);
  assign jump32   = {pc32[31:28], ir[25:0], 2'b00};
  assign branch32 = pc32 + {{14{imm[15]}}, imm, 2'b00};

  // Execute-stage decode and R-type ALU
  logic        is_rtype, is_beq, is_j, is_lw, is_sw, is_addi;
  logic        r_legal;
  logic        exec_illegal;
  logic [31:0] r_result;

  assign is_rtype = (opcode == OP_RTYPE);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_j     = (opcode == OP_J);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_addi  = (opcode == OP_ADDI);

  always_comb begin
    r_result = '0;
    r_legal  = 1'b1;
    case (funct)
      FN_ADD:  r_result = a_reg + b_reg;
      FN_SUB:  r_result = a_reg - b_reg;
      FN_AND:  r_result = a_reg & b_reg;
      FN_OR:   r_result = a_reg | b_reg;
      FN_SLT:  r_result = ($signed(a_reg) < $signed(b_reg)) ? 32'd1 : 32'd0;
      FN_SLL:  r_result = b_reg << shamt;
      FN_SRL:  r_result = b_reg >> shamt;
      default: r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    exec_illegal = 1'b0;
    if (is_rtype)
      exec_illegal = !r_legal;
    else if (!(is_addi || is_lw || is_sw || is_beq || is_j))
      exec_illegal = 1'b1;
  end

  // Write-back selection
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;

  assign wb_dest  = is_rtype ? rd : rt;
  assign wb_value = is_lw ? mdr : alu_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH_WAIT0;
      pc      <= RESET_PC[ADDR_W-1:0];
      cur_pc  <= '0;
      ir      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH_WAIT0: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir     <= mem_rdata;
            cur_pc <= pc;
            pc     <= pc + ADDR_W'(4);
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg   <= regs[rs];
          b_reg   <= regs[rt];
          alu_out <= branch32;
          state   <= (opcode == HALT_OP) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          if (is_rtype) begin
            if (r_legal) begin
              alu_out <= r_result;
              state   <= S_WB;
            end
          end else if (is_addi) begin
            alu_out <= a_reg + sext_imm;
            state   <= S_WB;
          end else if (is_lw || is_sw) begin
            alu_out <= a_reg + sext_imm;
            state   <= S_MEM;
          end else if (is_beq) begin
            // alu_out still holds the branch target computed in DECODE
            if (a_reg == b_reg) pc <= alu_out[ADDR_W-1:0];
          end else if (is_j) begin
            pc <= jump32[ADDR_W-1:0];
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_lw) begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (wb_dest != 5'd0) regs[wb_dest] <= wb_value;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH_WAIT0;
      endcase
    end
  end

  // Outputs are forced quiet while reset is high so nothing leaks out in the
  // cycle before the reset edge takes effect.
  logic active;
  logic in_mem;
  assign active = !reset;
  assign in_mem = (state == S_MEM);

  always_comb begin
    mem_req    = active && ((state == S_FETCH) || in_mem);
    mem_we     = active && in_mem && is_sw;
    mem_wdata  = (active && in_mem && is_sw) ? b_reg : '0;
    if (!active)
      mem_addr = RESET_PC[ADDR_W-1:0];
    else if (in_mem)
      mem_addr = {alu_out[ADDR_W-1:2], 2'b00};
    else
      mem_addr = {pc[ADDR_W-1:2], 2'b00};

    halted     = active && (state == S_HALT);
    illegal_op = active && (state == S_EXEC) && exec_illegal;
    retire     = active && ((state == S_WB)
               || ((state == S_EXEC) && (is_beq || is_j || exec_illegal))
               || (in_mem && is_sw && mem_ready)
               || ((state == S_DECODE) && (opcode == HALT_OP)));
    retire_pc  = active ? cur_pc : '0;

    wb_en      = active && (state == S_WB) && (wb_dest != 5'd0);
    wb_reg     = (active && (state == S_WB)) ? wb_dest : '0;
    wb_data    = (active && (state == S_WB)) ? wb_value : '0;
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Testbench for mips_multicycle_core: directed programs plus a random program,
// checked against an instruction-level model of the MIPS subset.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        halted, illegal_op, retire, wb_en;
  logic [31:0] retire_pc;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  logic        rdy = 1'b1;
  logic [31:0] mem  [0:1023];
  logic [31:0] mmem [0:1023];
  logic [31:0] mregs [32];
  logic [31:0] mpc;

  assign mem_ready = rdy;
  assign mem_rdata = mem[mem_addr[11:2]];

  always #5 clk = ~clk;

  mips_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h0), .HALT_OP(6'h3F)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .illegal_op(illegal_op), .retire(retire),
    .retire_pc(retire_pc), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  int total = 0, bad = 0;
  int cyc = 0, prev_ret = 0, stalls = 0, stall_cnt = 0, ill_cnt = 0;
  bit rand_ready = 0, hold_data = 0, fetch_done = 0;

  // expected outcome of the instruction currently in flight
  logic [31:0] exp_pc, exp_data, exp_addr, exp_sdata;
  logic [4:0]  exp_reg;
  bit          exp_wb, exp_ill, exp_halt, exp_mem, exp_we;
  int          exp_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic summary();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word);
    mem[addr[11:2]]  = word;
    mmem[addr[11:2]] = word;
  endtask

  // One clock: choose mem_ready for this cycle, then sample after settling.
  task automatic tick();
    @(negedge clk);
    if (hold_data && fetch_done) rdy = 1'b0;
    else if (stall_cnt > 0 && mem_req) begin rdy = 1'b0; stall_cnt--; end
    else if (rand_ready) rdy = ($urandom_range(0, 2) != 0);
    else rdy = 1'b1;
    #1;
    cyc++;
    if (mem_req && !rdy) stalls++;
    if (mem_req && mem_we && rdy) mem[mem_addr[11:2]] = mem_wdata;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc = 32'h0;
  endtask

  // Architectural effect of one instruction.
  task automatic model_step();
    logic [31:0] ir, va, vb, val, sx;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, dst;
    bit          wr;
    ir = mmem[mpc[11:2]];
    exp_pc = mpc;
    mpc = mpc + 32'd4;
    op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
    sh = ir[10:6];  fn = ir[5:0];
    va = mregs[rs]; vb = mregs[rt];
    sx = {{16{ir[15]}}, ir[15:0]};
    exp_wb = 0; exp_reg = '0; exp_data = '0; exp_ill = 0; exp_halt = 0;
    exp_mem = 0; exp_we = 0; exp_addr = '0; exp_sdata = '0;
    wr = 0; dst = '0; val = '0; exp_lat = 3;
    if (op == 6'h3F) begin
      exp_halt = 1; exp_lat = 2;
    end else begin
      case (op)
        6'h00: begin
          exp_lat = 4; dst = rd; wr = 1;
          case (fn)
            6'h20: val = va + vb;
            6'h22: val = va - vb;
            6'h24: val = va & vb;
            6'h25: val = va | vb;
            6'h2A: val = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
            6'h00: val = vb << sh;
            6'h02: val = vb >> sh;
            default: begin wr = 0; exp_ill = 1; exp_lat = 3; end
          endcase
        end
        6'h08: begin exp_lat = 4; dst = rt; wr = 1; val = va + sx; end
        6'h23: begin
          exp_lat = 5; exp_mem = 1; exp_addr = (va + sx) & ~32'd3;
          val = mmem[exp_addr[11:2]]; dst = rt; wr = 1;
        end
        6'h2B: begin
          exp_lat = 4; exp_mem = 1; exp_we = 1; exp_addr = (va + sx) & ~32'd3;
          exp_sdata = vb; mmem[exp_addr[11:2]] = vb;
        end
        6'h04: if (va == vb) mpc = mpc + (sx << 2);
        6'h02: mpc = {mpc[31:28], ir[25:0], 2'b00};
        default: exp_ill = 1;
      endcase
    end
    if (wr && dst != 5'd0) begin
      mregs[dst] = val; exp_wb = 1; exp_reg = dst; exp_data = val;
    end
  endtask

  task automatic expect_retire();
    bit found = 0;
    model_step();
    for (int k = 0; k < 200 && !found; k++) begin
      tick();
      if (mem_req) begin
        if (!fetch_done) begin
          chk("fetch_addr", mem_addr, exp_pc);
          chk("fetch_we", 32'(mem_we), 32'd0);
          if (rdy) fetch_done = 1;
        end else begin
          chk("data_req_expected", 32'(exp_mem), 32'd1);
          chk("data_addr", mem_addr, exp_addr);
          chk("data_we", 32'(mem_we), 32'(exp_we));
          if (exp_we) chk("store_data", mem_wdata, exp_sdata);
        end
      end
      if (retire) found = 1;
      else chk("idle_strobes", {29'd0, wb_en, illegal_op, halted}, 32'd0);
    end
    chk("retire_seen", 32'(found), 32'd1);
    if (!found) summary();
    chk("retire_pc", retire_pc, exp_pc);
    chk("illegal_op", 32'(illegal_op), 32'(exp_ill));
    chk("wb_en", 32'(wb_en), 32'(exp_wb));
    if (exp_wb) begin
      chk("wb_reg", 32'(wb_reg), 32'(exp_reg));
      chk("wb_data", wb_data, exp_data);
    end
    chk("latency", 32'(cyc - prev_ret), 32'(exp_lat + stalls));
    if (illegal_op) ill_cnt++;
    prev_ret = cyc; stalls = 0; fetch_done = 0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1; fetch_done = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_strobes", {28'd0, retire, wb_en, illegal_op, halted}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
    end
    reset = 1'b0; stalls = 0;
    tick();
    chk("rel_req", 32'(mem_req), 32'd1);
    chk("rel_addr", mem_addr, 32'h0);
    chk("rel_we", 32'(mem_we), 32'd0);
    if (rdy) fetch_done = 1;
    prev_ret = cyc - 1;
  endtask

  task automatic run_to_halt(input int max_instr);
    for (int i = 0; i < max_instr; i++) begin
      expect_retire();
      if (exp_halt) break;
    end
    chk("reached_halt", 32'(exp_halt), 32'd1);
  endtask

  logic [31:0] tbl_data [5];
  logic [5:0]  fl [7];

  initial begin
    tbl_data = '{32'd5, 32'hFFFF_FFFD, 32'd2, 32'd20, 32'd1};
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; mmem[i] = '0; end

    // Directed program: ALU ops, jump, sw/lw, countdown loop, $0, illegal, halt
    put(32'h000, i_ins(6'h08, 5'd0, 5'd1, 16'd5));
    put(32'h004, i_ins(6'h08, 5'd0, 5'd2, 16'hFFFD));
    put(32'h008, r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
    put(32'h00C, r_ins(5'd0, 5'd1, 5'd4, 5'd2, 6'h00));
    put(32'h010, r_ins(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A));
    put(32'h014, {6'h02, 26'h40});
    put(32'h018, i_ins(6'h08, 5'd0, 5'd7, 16'd99));
    put(32'h100, i_ins(6'h08, 5'd0, 5'd1, 16'h40));
    put(32'h104, i_ins(6'h2B, 5'd1, 5'd1, 16'd4));
    put(32'h108, i_ins(6'h23, 5'd1, 5'd2, 16'd4));
    put(32'h10C, i_ins(6'h08, 5'd0, 5'd6, 16'd3));
    put(32'h110, i_ins(6'h08, 5'd6, 5'd6, 16'hFFFF));
    put(32'h114, i_ins(6'h04, 5'd6, 5'd0, 16'd1));
    put(32'h118, i_ins(6'h04, 5'd0, 5'd0, 16'hFFFD));
    put(32'h11C, i_ins(6'h08, 5'd0, 5'd0, 16'd7));
    put(32'h120, {6'h3E, 26'h0});
    put(32'h124, r_ins(5'd2, 5'd1, 5'd8, 5'd0, 6'h22));
    put(32'h128, r_ins(5'd1, 5'd4, 5'd9, 5'd0, 6'h25));
    put(32'h12C, r_ins(5'd9, 5'd1, 5'd10, 5'd0, 6'h24));
    put(32'h130, r_ins(5'd0, 5'd9, 5'd11, 5'd2, 6'h02));
    put(32'h134, r_ins(5'd0, 5'd0, 5'd0, 5'd0, 6'h3F));
    put(32'h138, {6'h3F, 26'h0});

    apply_reset(3);
    model_reset();
    for (int i = 0; i < 60; i++) begin
      if (mpc == 32'h124) stall_cnt = 3;   // 3-cycle fetch stall on the sub
      expect_retire();
      if (i < 5) begin
        chk("trace_reg", 32'(wb_reg), 32'(i + 1));
        chk("trace_data", wb_data, tbl_data[i]);
      end
      if (exp_halt) break;
    end
    chk("reached_halt", 32'(exp_halt), 32'd1);
    chk("illegal_count", 32'(ill_cnt), 32'd2);
    chk("sw_word_0x44", mem[17], 32'h40);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("halt_state", {29'd0, halted, mem_req, retire}, 32'd4);
    end

    // Random program under random memory latency
    for (int w = 0; w < 16; w++) put(32'h800 + 32'(4 * w), $urandom);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ins;
      logic [4:0]  ra, rb, rc;
      int          kind;
      kind = $urandom_range(0, 9);
      ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rc = 5'($urandom_range(0, 7));
      case (kind)
        0, 1, 2: ins = r_ins(ra, rb, rc, 5'($urandom_range(0, 31)), fl[$urandom_range(0, 6)]);
        3, 4, 9: ins = i_ins(6'h08, ra, rb, 16'($urandom));
        5:       ins = i_ins(6'h23, 5'd0, rb, 16'(32'h800 + 4 * $urandom_range(0, 15)));
        6:       ins = i_ins(6'h2B, 5'd0, rb, 16'(32'h800 + 4 * $urandom_range(0, 15)));
        7:       ins = i_ins(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                             16'($urandom_range(0, 3)));
        default: ins = ($urandom_range(0, 1) != 0) ? {6'h3E, 26'($urandom)}
                                                   : r_ins(ra, rb, rc, 5'd0, 6'h3F);
      endcase
      put(32'(4 * i), ins);
    end
    for (int i = 40; i < 44; i++) put(32'(4 * i), {6'h3F, 26'h0});

    apply_reset(2);
    model_reset();
    rand_ready = 1;
    run_to_halt(300);
    rand_ready = 0;
    for (int w = 0; w < 16; w++) chk("dmem", mem[512 + w], mmem[512 + w]);

    // Reset while an lw is stalled in its data access
    put(32'h000, r_ins(5'd7, 5'd8, 5'd5, 5'd0, 6'h25));
    put(32'h004, i_ins(6'h23, 5'd0, 5'd3, 16'h800));
    put(32'h008, {6'h3F, 26'h0});
    apply_reset(2);
    model_reset();
    expect_retire();
    hold_data = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (mem_req && rdy && !fetch_done) fetch_done = 1;
      chk("hold_quiet", {30'd0, retire, wb_en}, 32'd0);
    end
    chk("hold_req", 32'(mem_req), 32'd1);
    chk("hold_addr", mem_addr, 32'h800);
    chk("hold_we", 32'(mem_we), 32'd0);
    hold_data = 0;
    apply_reset(1);
    model_reset();
    run_to_halt(5);
    tick();
    chk("final_halted", 32'(halted), 32'd1);

    summary();
  end

endmodule
